// File: rtl/fwd_sel_gen.sv
// Forwarding-select generator: shadows in-flight destinations, registers the
// EX operand-mux selects at the ID->EX edge and raises a load-use stall.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   id_valid              ID holds a real instruction
//   id_rs1, id_rs2        ID source registers (rs2=0 when unused)
//   id_rd                 ID destination register
//   id_reg_write          ID instruction writes rd
//   id_mem_read           ID instruction is a load
//   flush                 kill the ID instruction (taken branch in EX)
//   fwd_a, fwd_b          operand mux selects: 00 RF, 01 MEM/WB, 10 EX/MEM
//   stall                 load-use hazard, combinational
//   stall_cnt             saturating count of stall cycles
module fwd_sel_gen #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } shd_t;

  localparam shd_t BUBBLE = '0;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // s1 = ID/EX, s2 = EX/MEM, s3 = MEM/WB
  shd_t s1_q, s1_d;
  shd_t s2_q;
  shd_t s3_q;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_w;

  function automatic logic hit(
    input shd_t                  s,
    input logic [REG_ADDR_W-1:0] r
  );
    return s.wr && (s.rd != '0) && (s.rd == r);
  endfunction

  // Decided at the ID->EX edge: an s1 producer will then sit in MEM,
  // an s2 producer in WB. The nearer one holds the newer value.
  function automatic logic [1:0] sel(
    input shd_t                  a,
    input shd_t                  b,
    input logic [REG_ADDR_W-1:0] r
  );
    if (hit(a, r))      return SEL_MEM;
    else if (hit(b, r)) return SEL_WB;
    else                return SEL_RF;
  endfunction

  assign stall_w = id_valid && !flush && s1_q.ld &&
                   (hit(s1_q, id_rs1) || hit(s1_q, id_rs2));

  always_comb begin
    s1_d    = BUBBLE;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    cnt_d   = cnt_q;
    if (flush) begin
      s1_d = BUBBLE;
    end else if (stall_w) begin
      // ID instruction is held; next cycle the load is in s2 -> 01
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end else if (!id_valid) begin
      s1_d = BUBBLE;
    end else begin
      s1_d    = '{rd: id_rd, wr: id_reg_write, ld: id_mem_read};
      fwd_a_d = sel(s1_q, s2_q, id_rs1);
      fwd_b_d = sel(s1_q, s2_q, id_rs2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= BUBBLE;
      s2_q    <= BUBBLE;
      s3_q    <= BUBBLE;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      s3_q    <= s2_q;
      s2_q    <= s1_q;
      s1_q    <= s1_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall     = stall_w;
  assign stall_cnt = cnt_q;

  // The MEM/WB shadow has already reached the register file by the time
  // a consumer reads it, so it never selects a bypass.
  logic unused_s3;
  assign unused_s3 = ^s3_q;

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Directed testbench for fwd_sel_gen.
// Two instances: default CNT_W and CNT_W=2 for saturation.
module tb_fwd_sel_gen;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, flush;

  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] stall_cnt;

  logic [1:0]  fwd_a2, fwd_b2;
  logic        stall2;
  logic [1:0]  stall_cnt2;

  int checks;
  int failures;

  fwd_sel_gen #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_sel_gen #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stall(stall2), .stall_cnt(stall_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(
    input logic       v,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [4:0] rd,
    input logic       wr,
    input logic       ld,
    input logic       fl
  );
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = wr;
    id_mem_read  = ld;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    checks += 4;
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a);
    end
    if (fwd_b !== 2'b00) begin
      failures++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b);
    end
    if (stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", stall);
    end
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ex_ex();
    drive(1, 1, 2, 5, 1, 0, 0);
    step();
    drive(1, 5, 0, 6, 1, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL exex_stall got=%b exp=0", stall);
    end
    step();
    checks += 2;
    if (fwd_a !== 2'b10) begin
      failures++; $display("FAIL exex_fwd_a got=%b exp=10", fwd_a);
    end
    if (fwd_b !== 2'b00) begin
      failures++; $display("FAIL exex_fwd_b got=%b exp=00", fwd_b);
    end
    idle(3);
  endtask

  task automatic test_mem_ex();
    drive(1, 0, 0, 7, 1, 0, 0);
    step();
    drive(1, 1, 2, 8, 1, 0, 0);
    step();
    drive(1, 0, 7, 0, 0, 0, 0);
    step();
    checks += 2;
    if (fwd_b !== 2'b01) begin
      failures++; $display("FAIL memex_fwd_b got=%b exp=01", fwd_b);
    end
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL memex_fwd_a got=%b exp=00", fwd_a);
    end
    idle(3);
  endtask

  task automatic test_priority_x0();
    drive(1, 0, 0, 3, 1, 0, 0);
    step();
    drive(1, 0, 0, 3, 1, 0, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (fwd_a !== 2'b10) begin
      failures++; $display("FAIL prio_fwd_a got=%b exp=10", fwd_a);
    end
    drive(1, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 4, 0, 0, 0);
    step();
    checks += 2;
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL x0_fwd_a got=%b exp=00", fwd_a);
    end
    if (fwd_b !== 2'b00) begin
      failures++; $display("FAIL x0_fwd_b got=%b exp=00", fwd_b);
    end
    idle(3);
  endtask

  task automatic test_load_use();
    drive(1, 1, 0, 9, 1, 1, 0);
    step();
    drive(1, 9, 0, 10, 1, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", stall);
    end
    step();
    checks += 4;
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL lu_bubble_fwd_a got=%b exp=00", fwd_a);
    end
    if (fwd_b !== 2'b00) begin
      failures++; $display("FAIL lu_bubble_fwd_b got=%b exp=00", fwd_b);
    end
    if (stall !== 1'b0) begin
      failures++; $display("FAIL lu_stall_once got=%b exp=0", stall);
    end
    if (stall_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt);
    end
    step();
    checks += 2;
    if (fwd_a !== 2'b01) begin
      failures++; $display("FAIL lu_fwd_a got=%b exp=01", fwd_a);
    end
    if (stall_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_cnt_hold got=%0d exp=1", stall_cnt);
    end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1, 1, 0, 9, 1, 1, 0);
    step();
    drive(1, 9, 0, 10, 1, 0, 1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL fl_stall got=%b exp=0", stall);
    end
    step();
    checks += 3;
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL fl_fwd_a got=%b exp=00", fwd_a);
    end
    if (fwd_b !== 2'b00) begin
      failures++; $display("FAIL fl_fwd_b got=%b exp=00", fwd_b);
    end
    if (stall_cnt !== 16'd1) begin
      failures++; $display("FAIL fl_cnt got=%0d exp=1", stall_cnt);
    end
    // s1 must be a bubble: rd=10 not seen, load (s2) seen as 01
    drive(1, 10, 9, 0, 0, 0, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL fl_nostall got=%b exp=0", stall);
    end
    step();
    checks += 2;
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL fl_s1_bubble got=%b exp=00", fwd_a);
    end
    if (fwd_b !== 2'b01) begin
      failures++; $display("FAIL fl_load_s2 got=%b exp=01", fwd_b);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 4, 1, 0, 0);
    step();
    drive(1, 4, 0, 9, 1, 1, 0);
    step();
    drive(1, 9, 0, 10, 1, 0, 0);
    #1;
    checks += 2;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL rms_pre_stall got=%b exp=1", stall);
    end
    if (fwd_a !== 2'b10) begin
      failures++; $display("FAIL rms_pre_fwd_a got=%b exp=10", fwd_a);
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rms_stall got=%b exp=0", stall);
    end
    if (fwd_a !== 2'b00) begin
      failures++; $display("FAIL rms_fwd_a got=%b exp=00", fwd_a);
    end
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL rms_cnt got=%0d exp=0", stall_cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int e2;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 9, 1, 1, 0);
      step();
      drive(1, 9, 0, 10, 1, 0, 0);
      #1;
      checks++;
      if (stall2 !== 1'b1) begin
        failures++; $display("FAIL sat_stall[%0d] got=%b exp=1", i, stall2);
      end
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      e2 = (i + 1 > 3) ? 3 : i + 1;
      checks += 2;
      if (stall_cnt2 !== 2'(e2)) begin
        failures++;
        $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, stall_cnt2, e2);
      end
      if (stall_cnt !== 16'(i + 1)) begin
        failures++;
        $display("FAIL sat_cnt16[%0d] got=%0d exp=%0d", i, stall_cnt, i + 1);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ex_ex();
    test_mem_ex();
    test_priority_x0();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
